// File: rtl/stack_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// stack_ctrl_pkg
// Shared types and constants for the stack sequencer.
//   op_code_e : request opcodes carried on op_code
//   state_e   : sequencer FSM states (IDLE -> EXEC -> RESP -> IDLE)
//   MEM_RW_*  : encodings driven on the stack memory's mem_rw port
// -----------------------------------------------------------------------------
package stack_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_PEEK = 2'b11
  } op_code_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [3:0] MEM_RW_WRITE = 4'h1;
  localparam logic [3:0] MEM_RW_IDLE  = 4'h0;

endpackage

// File: rtl/stack_controller.sv
// -----------------------------------------------------------------------------
// stack_controller
// Owns the stack pointer of a full-descending stack and drives the stack
// memory port for one PUSH/POP/PEEK/NOP request at a time. Each accepted
// request runs IDLE -> EXEC -> RESP, giving one operation per three cycles.
//
// Configuration macro:
//   STACK_CTRL_PEEK_EN  defined   : op_code 11 reads the top element.
//                       undefined : op_code 11 is answered with rsp_err=1.
//
// Ports:
//   clock      single clock, all state changes on posedge
//   reset      synchronous, active-high
//   op_valid   request present
//   op_ready   request can be accepted (IDLE only)
//   op_code    00 NOP, 01 PUSH, 10 POP, 11 PEEK
//   op_wdata   PUSH data, sampled at accept
//   rsp_valid  one-cycle response strobe
//   rsp_data   POP/PEEK data, otherwise 0
//   rsp_err    overflow/underflow/illegal op, qualified by rsp_valid
//   mem_rw     4'h1 write, 4'h0 no write
//   mem_esp    memory word address, zero-extended to 32 bits
//   mem_wdata  memory write data
//   mem_rdata  combinational read of mem[mem_esp]
//   esp        architectural stack pointer (DEPTH when empty)
//   full       esp == 0
//   empty      esp == DEPTH
// -----------------------------------------------------------------------------
module stack_controller
  import stack_ctrl_pkg::*;
#(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [1:0]        op_code,
  input  logic [DATA_W-1:0] op_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic [3:0]        mem_rw,
  output logic [31:0]       mem_esp,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W:0]   esp,
  output logic              full,
  output logic              empty
);

  localparam logic [ADDR_W:0] ESP_EMPTY = (ADDR_W + 1)'(DEPTH);

  state_e          state;
  op_code_e        op_q;
  logic            err_q;
  logic [ADDR_W:0] esp_q;
  logic [ADDR_W:0] mem_esp_q;

  op_code_e        req_op;
  logic            req_err;
  logic            exec_read;

  assign esp     = esp_q;
  assign full    = (esp_q == '0);
  assign empty   = (esp_q == ESP_EMPTY);
  assign mem_esp = 32'(mem_esp_q);
  assign req_op  = op_code_e'(op_code);

  // Error classification of the request currently offered on op_*.
  // NOTE: every combinational output gets a default first so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    req_err = 1'b0;
    case (req_op)
      OP_PUSH: req_err = full;
      OP_POP:  req_err = empty;
`ifdef STACK_CTRL_PEEK_EN
      OP_PEEK: req_err = empty;
`else
      OP_PEEK: req_err = 1'b1;
`endif
      default: req_err = 1'b0;
    endcase
  end

  // A good POP or PEEK returns the word the memory presents during EXEC.
  // With PEEK compiled out err_q is always set for OP_PEEK, so no read.
  assign exec_read = !err_q && ((op_q == OP_POP) || (op_q == OP_PEEK));

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      op_q      <= OP_NOP;
      err_q     <= 1'b0;
      esp_q     <= ESP_EMPTY;
      op_ready  <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_data  <= '0;
      mem_rw    <= MEM_RW_IDLE;
      mem_esp_q <= ESP_EMPTY;
      mem_wdata <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (op_valid) begin
            op_q     <= req_op;
            err_q    <= req_err;
            op_ready <= 1'b0;
            state    <= ST_EXEC;
            if ((req_op == OP_PUSH) && !req_err) begin
              // Full-descending: the new top lives one below the old top.
              mem_rw    <= MEM_RW_WRITE;
              mem_esp_q <= esp_q - 1'b1;
              mem_wdata <= op_wdata;
            end else begin
              mem_rw    <= MEM_RW_IDLE;
              mem_esp_q <= esp_q;
            end
          end
        end

        ST_EXEC: begin
          // The write strobe covers exactly this cycle.
          mem_rw    <= MEM_RW_IDLE;
          rsp_valid <= 1'b1;
          rsp_err   <= err_q;
          rsp_data  <= exec_read ? mem_rdata : '0;
          if (!err_q && (op_q == OP_PUSH)) begin
            esp_q <= esp_q - 1'b1;
          end else if (!err_q && (op_q == OP_POP)) begin
            esp_q <= esp_q + 1'b1;
          end
          state <= ST_RESP;
        end

        ST_RESP: begin
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          rsp_data  <= '0;
          op_ready  <= 1'b1;
          state     <= ST_IDLE;
        end

        default: begin
          state    <= ST_IDLE;
          op_ready <= 1'b1;
          mem_rw   <= MEM_RW_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stack_controller.sv
// -----------------------------------------------------------------------------
// tb_stack_controller
// Self-checking bench for stack_controller. A behavioural 32-word memory
// (negedge write, combinational read) is attached to the memory port.
// Directed vectors from a table, hand-written sequences for fill/overflow
// and reset corners, then randomized operations compared with a queue model.
// Honours STACK_CTRL_PEEK_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_stack_controller;
  import stack_ctrl_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        op_valid;
  logic        op_ready;
  logic [1:0]  op_code;
  logic [31:0] op_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [3:0]  mem_rw;
  logic [31:0] mem_esp;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic [5:0]  esp;
  logic        full;
  logic        empty;

  int errors = 0;
  int checks = 0;

  logic [31:0] tb_mem [0:31];

  stack_controller #(.DEPTH(32), .ADDR_W(5), .DATA_W(32)) dut (
    .clock     (clock),
    .reset     (reset),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op_code   (op_code),
    .op_wdata  (op_wdata),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .mem_rw    (mem_rw),
    .mem_esp   (mem_esp),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .esp       (esp),
    .full      (full),
    .empty     (empty)
  );

  always #5 clock = ~clock;

  // Behavioural stack memory.
  always @(negedge clock) begin
    if (mem_rw == 4'h1 && mem_esp < 32) tb_mem[mem_esp[4:0]] <= mem_wdata;
  end
  always_comb mem_rdata = (mem_esp < 32) ? tb_mem[mem_esp[4:0]] : 32'h0;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Issues one request from an IDLE negedge and checks EXEC, RESP and the
  // following IDLE cycle. Returns at the IDLE negedge, ready for the next op.
  task automatic run_op(input string tag, input logic [1:0] code, input logic [31:0] wd,
                        input logic exp_err, input logic [31:0] exp_data,
                        input logic [5:0] exp_esp, input logic [3:0] exp_rw,
                        input logic chk_me, input logic [31:0] exp_me);
    int waited = 0;
    while (!op_ready && waited < 4) begin
      @(negedge clock);
      waited++;
    end
    check({tag, ".ready"}, 64'(op_ready), 64'(1'b1));
    op_valid = 1'b1;
    op_code  = code;
    op_wdata = wd;
    @(negedge clock);                       // EXEC
    op_valid = 1'b0;
    check({tag, ".exec_ready"}, 64'(op_ready), 64'(1'b0));
    check({tag, ".exec_rsp_valid"}, 64'(rsp_valid), 64'(1'b0));
    check({tag, ".exec_rw"}, 64'(mem_rw), 64'(exp_rw));
    if (exp_rw == 4'h1) check({tag, ".exec_wdata"}, 64'(mem_wdata), 64'(wd));
    if (chk_me) check({tag, ".exec_mem_esp"}, 64'(mem_esp), 64'(exp_me));
    @(negedge clock);                       // RESP
    check({tag, ".rsp_valid"}, 64'(rsp_valid), 64'(1'b1));
    check({tag, ".rsp_err"}, 64'(rsp_err), 64'(exp_err));
    check({tag, ".rsp_data"}, 64'(rsp_data), 64'(exp_data));
    check({tag, ".rsp_rw"}, 64'(mem_rw), 64'(4'h0));
    check({tag, ".esp"}, 64'(esp), 64'(exp_esp));
    check({tag, ".empty"}, 64'(empty), 64'(exp_esp == 6'd32));
    check({tag, ".full"}, 64'(full), 64'(exp_esp == 6'd0));
    @(negedge clock);                       // IDLE again
    check({tag, ".idle_ready"}, 64'(op_ready), 64'(1'b1));
    check({tag, ".idle_rsp_valid"}, 64'(rsp_valid), 64'(1'b0));
  endtask

  typedef struct {
    logic [1:0]  code;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] data;
    logic [5:0]  esp;
    logic [3:0]  rw;
    logic        chk_me;
    logic [31:0] me;
  } vec_t;

  vec_t vecs [10];

  // Queue model: front is top of stack.
  logic [31:0] model_q [$];

  task automatic random_phase(input string tag, input int n, input int push_w, input int pop_w);
    for (int k = 0; k < n; k++) begin
      int          r;
      logic [1:0]  code;
      logic [31:0] wd;
      logic        e_err;
      logic [31:0] e_data;
      logic [3:0]  e_rw;
      logic        e_chk;
      logic [31:0] e_me;
      int          depth_before;
      r  = $urandom_range(0, 99);
      wd = $urandom;
      if (r < 10) code = 2'(OP_NOP);
      else if (r < 10 + push_w) code = 2'(OP_PUSH);
      else if (r < 10 + push_w + pop_w) code = 2'(OP_POP);
      else code = 2'(OP_PEEK);
      depth_before = model_q.size();
      e_err = 1'b0; e_data = 32'h0; e_rw = 4'h0; e_chk = 1'b0; e_me = 32'h0;
      case (code)
        2'(OP_PUSH): begin
          if (depth_before == 32) e_err = 1'b1;
          else begin
            e_rw = 4'h1; e_chk = 1'b1; e_me = 32'(32 - depth_before - 1);
            model_q.push_front(wd);
          end
        end
        2'(OP_POP): begin
          if (depth_before == 0) e_err = 1'b1;
          else begin
            e_chk = 1'b1; e_me = 32'(32 - depth_before);
            e_data = model_q.pop_front();
          end
        end
        2'(OP_PEEK): begin
`ifdef STACK_CTRL_PEEK_EN
          if (depth_before == 0) e_err = 1'b1;
          else begin
            e_chk = 1'b1; e_me = 32'(32 - depth_before);
            e_data = model_q[0];
          end
`else
          e_err = 1'b1;
`endif
        end
        default: ;
      endcase
      run_op(tag, code, wd, e_err, e_data, 6'(32 - model_q.size()), e_rw, e_chk, e_me);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) tb_mem[i] = 32'h0;
    reset    = 1'b1;
    op_valid = 1'b0;
    op_code  = 2'b00;
    op_wdata = 32'h0;

    vecs[0] = '{2'(OP_PUSH), 32'hDEADBEEF, 1'b0, 32'h0,        6'd31, 4'h1, 1'b1, 32'd31};
    vecs[1] = '{2'(OP_POP),  32'h0,        1'b0, 32'hDEADBEEF, 6'd32, 4'h0, 1'b1, 32'd31};
    vecs[2] = '{2'(OP_POP),  32'h0,        1'b1, 32'h0,        6'd32, 4'h0, 1'b0, 32'd0};
    vecs[3] = '{2'(OP_NOP),  32'h0000AAAA, 1'b0, 32'h0,        6'd32, 4'h0, 1'b0, 32'd0};
    vecs[4] = '{2'(OP_PEEK), 32'h0,        1'b1, 32'h0,        6'd32, 4'h0, 1'b0, 32'd0};
    vecs[5] = '{2'(OP_PUSH), 32'h12345678, 1'b0, 32'h0,        6'd31, 4'h1, 1'b1, 32'd31};
    vecs[6] = '{2'(OP_PUSH), 32'hCAFEF00D, 1'b0, 32'h0,        6'd30, 4'h1, 1'b1, 32'd30};
`ifdef STACK_CTRL_PEEK_EN
    vecs[7] = '{2'(OP_PEEK), 32'h0,        1'b0, 32'hCAFEF00D, 6'd30, 4'h0, 1'b1, 32'd30};
`else
    vecs[7] = '{2'(OP_PEEK), 32'h0,        1'b1, 32'h0,        6'd30, 4'h0, 1'b0, 32'd0};
`endif
    vecs[8] = '{2'(OP_POP),  32'h0,        1'b0, 32'hCAFEF00D, 6'd31, 4'h0, 1'b1, 32'd30};
    vecs[9] = '{2'(OP_POP),  32'h0,        1'b0, 32'h12345678, 6'd32, 4'h0, 1'b1, 32'd31};

    repeat (3) @(negedge clock);
    reset = 1'b0;

    // Reset state.
    check("rst.esp",       64'(esp),       64'd32);
    check("rst.empty",     64'(empty),     64'd1);
    check("rst.full",      64'(full),      64'd0);
    check("rst.op_ready",  64'(op_ready),  64'd1);
    check("rst.mem_rw",    64'(mem_rw),    64'd0);
    check("rst.rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst.rsp_err",   64'(rsp_err),   64'd0);
    check("rst.rsp_data",  64'(rsp_data),  64'd0);
    check("rst.mem_esp",   64'(mem_esp),   64'd32);
    check("rst.mem_wdata", 64'(mem_wdata), 64'd0);

    // Directed table.
    for (int i = 0; i < 10; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].code, vecs[i].wdata, vecs[i].err,
             vecs[i].data, vecs[i].esp, vecs[i].rw, vecs[i].chk_me, vecs[i].me);
    end

    // Fill: 32 pushes of 0..31.
    for (int i = 0; i < 32; i++) begin
      run_op($sformatf("fill%0d", i), 2'(OP_PUSH), 32'(i), 1'b0, 32'h0,
             6'(31 - i), 4'h1, 1'b1, 32'(31 - i));
    end
    check("fill.full", 64'(full), 64'd1);
    check("fill.esp",  64'(esp),  64'd0);

    // Overflow: no write, error, esp held.
    run_op("overflow", 2'(OP_PUSH), 32'hBADBAD00, 1'b1, 32'h0, 6'd0, 4'h0, 1'b0, 32'h0);
`ifdef STACK_CTRL_PEEK_EN
    run_op("peek_full", 2'(OP_PEEK), 32'h0, 1'b0, 32'd31, 6'd0, 4'h0, 1'b1, 32'd0);
`else
    run_op("peek_full", 2'(OP_PEEK), 32'h0, 1'b1, 32'h0, 6'd0, 4'h0, 1'b0, 32'h0);
`endif

    // Reset coincident with a PUSH accept: accept is discarded.
    op_valid = 1'b1; op_code = 2'(OP_PUSH); op_wdata = 32'h55AA55AA; reset = 1'b1;
    @(negedge clock);
    op_valid = 1'b0; reset = 1'b0;
    check("rst_acc.mem_rw",    64'(mem_rw),    64'd0);
    check("rst_acc.op_ready",  64'(op_ready),  64'd1);
    check("rst_acc.rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_acc.esp",       64'(esp),       64'd32);
    @(negedge clock);
    check("rst_acc.rsp_valid2", 64'(rsp_valid), 64'd0);
    check("rst_acc.mem_rw2",    64'(mem_rw),    64'd0);

    // Reset during EXEC of a PUSH: write stays visible, esp still reset.
    op_valid = 1'b1; op_code = 2'(OP_PUSH); op_wdata = 32'h0BADF00D;
    @(negedge clock);
    op_valid = 1'b0;
    check("rst_exec.mem_rw", 64'(mem_rw), 64'd1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("rst_exec.esp",       64'(esp),       64'd32);
    check("rst_exec.op_ready",  64'(op_ready),  64'd1);
    check("rst_exec.rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_exec.mem_rw2",   64'(mem_rw),    64'd0);
    @(negedge clock);
    check("rst_exec.rsp_valid2", 64'(rsp_valid), 64'd0);

    // Randomized against the queue model (stack is empty after reset).
    model_q.delete();
    random_phase("rnd_fill",  160, 60, 15);
    random_phase("rnd_drain", 160, 15, 60);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
